ws2812_pixel_feeder: RTL and testbench
======================================

Name: ws2812_pixel_feeder

Overview:
- Upstream stage of the WS2812B bit-serializer in the LED controller.
- Holds a small GRB pixel buffer that a host can write at any time.
- On each frame request, streams one 24-bit word per LED to the serializer over a valid/ready handshake and flags the last word.
- Optional per-frame rotation of the start index produces the chasing-colour pattern; an internal refresh timer can issue frame requests automatically.

Parameters:
- NUM_LEDS, 3: number of pixels per frame; must be ≥ 1 and ≤ 2**ADDR_W.
- ADDR_W, 2: width of buffer address and internal index registers.
- REFRESH_CYCLES, 1000000: auto-refresh period in clk cycles; must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  host buffer write strobe.
- wr_addr  input  ADDR_W  pixel index to write; values ≥ NUM_LEDS are ignored.
- wr_data  input  24  pixel colour, GRB order, bit 23 first on the wire.
- start  input  1  manual frame request, single-cycle pulse or level.
- auto_en  input  1  enables the refresh timer.
- rot_en  input  1  advance the start index by 1 at the end of each frame.
- pix_valid  output  1  pix_data is valid.
- pix_data  output  24  pixel word to the serializer.
- pix_last  output  1  current word is the final pixel of the frame.
- pix_ready  input  1  serializer accepts the word.
- frame_busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Decided interface rule: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset, asynchronous, effective immediately and also mid-frame:
  - state = IDLE; pix_valid, pix_last, frame_busy, frame_done = 0; pix_data = 0.
  - base = 0, idx = 0, pending = 0, timer = 0.
  - All NUM_LEDS buffer entries cleared to 0.
- Buffer: register array. A write with wr_addr < NUM_LEDS updates the entry at the clock edge. Writes are legal in every state.
- Refresh timer:
  - When auto_en = 1, counts 0..REFRESH_CYCLES-1 and wraps; tick = 1 in the wrap cycle.
  - When auto_en = 0, the timer is held at 0 and tick = 0.
- Request: req = start | tick.
  - A req while not IDLE sets pending. pending holds at most one request; extra requests are dropped.
  - start and tick in the same cycle count as one request.
- FSM:
  - IDLE: if req | pending → FETCH; idx = 0; clear pending (unless a new req arrives in that same cycle).
  - FETCH (1 cycle):
    - pix_data <= buf[(base+idx) mod NUM_LEDS].
    - Write-first bypass: if wr_en is high for that address in this cycle, load wr_data instead.
    - pix_last <= (idx == NUM_LEDS-1); pix_valid <= 1 → PRESENT.
  - PRESENT:
    - Hold pix_valid, pix_data and pix_last stable until pix_valid & pix_ready.
    - On transfer: pix_valid <= 0. If pix_last → DONE; else idx += 1 → FETCH.
  - DONE (1 cycle):
    - frame_done = 1; pix_last <= 0.
    - If rot_en: base <= (base == NUM_LEDS-1) ? 0 : base+1.
    - → IDLE.
- Outputs: frame_busy = (state != IDLE). frame_done is high only in DONE.
- Latency and throughput:
  - start sampled high in IDLE at edge 0 → FETCH at edge 1 → pix_valid = 1 after edge 2.
  - After each transfer, the next word is valid 2 edges later: at most one word per 2 cycles.
- pix_ready held high while pix_valid = 0 has no effect.
- Index arithmetic (base+idx) mod NUM_LEDS uses one conditional subtract. No division.
- NUM_LEDS = 1: every word carries pix_last = 1, and rotation leaves base at 0.

Test Plan:
- Reset, write buf0=0x0000FF, buf1=0x00FF00, buf2=0xFF0000, rot_en=0, start pulse, pix_ready=1 → words 0x0000FF, 0x00FF00, 0xFF0000; pix_last only on the third; frame_done pulses once 1 cycle after the third transfer; pix_valid first rises 2 cycles after start.
- Same buffer, rot_en=1, four back-to-back frames → first words 0x0000FF, 0x00FF00, 0xFF0000, 0x0000FF (base wraps 2→0).
- Backpressure: hold pix_ready=0 for 50 cycles on word 2 → pix_valid and pix_data=0x00FF00 stay stable throughout; transfer occurs on the first ready cycle.
- Pending: start pulses at cycles 3 and 5 of a busy frame → exactly one extra frame follows immediately after DONE→IDLE; no third frame.
- auto_en=1 with REFRESH_CYCLES=100 → frame starts every 100 cycles; auto_en=0 → no frames, timer at 0.
- Assert rst_n low mid-PRESENT → pix_valid, frame_busy and pix_data go to 0 immediately; after release, a start pulse yields 0x000000 for all words (buffer cleared).

Source files
------------

// File: rtl/ws2812_pixel_feeder.sv
// GRB pixel buffer feeding the WS2812B bit-serializer: one 24-bit word per LED per frame over
// valid/ready, with optional start-index rotation and an auto-refresh timer.
module ws2812_pixel_feeder #(
  parameter int unsigned NUM_LEDS       = 3,
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned REFRESH_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  input  logic              auto_en,
  input  logic              rot_en,
  output logic              pix_valid,
  output logic [23:0]       pix_data,
  output logic              pix_last,
  input  logic              pix_ready,
  output logic              frame_busy,
  output logic              frame_done
);

  localparam int unsigned       TW    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TW-1:0]     TMAX  = TW'(REFRESH_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W:0]   NUM   = (ADDR_W + 1)'(NUM_LEDS);

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StDone} state_e;

  state_e            state;
  logic [TW-1:0]     timer;
  logic              tick;
  logic              req;
  logic              pending;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W-1:0] rd_idx;
  logic              wr_hit;
  logic [23:0]       pix_buf [NUM_LEDS];

  assign tick   = auto_en && (timer == TMAX);
  assign req    = start || tick;
  assign wr_hit = wr_en && ({1'b0, wr_addr} < NUM);

  assign frame_busy = (state != StIdle);
  assign frame_done = (state == StDone);

  // base and idx are both below NUM_LEDS, so one conditional subtract wraps the sum
  always_comb begin
    sum    = {1'b0, base} + {1'b0, idx};
    rd_idx = (sum >= NUM) ? ADDR_W'(sum - NUM) : sum[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (!auto_en || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) pix_buf[i] <= '0;
    end else if (wr_hit) begin
      pix_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      pix_data  <= '0;
      base      <= '0;
      idx       <= '0;
      pending   <= 1'b0;
    end else begin
      if (req && state != StIdle) pending <= 1'b1;
      unique case (state)
        StIdle: begin
          if (req || pending) begin
            state   <= StFetch;
            idx     <= '0;
            // a fresh request arriving while a pending one is consumed stays queued
            pending <= pending && req;
          end
        end
        StFetch: begin
          pix_data  <= (wr_hit && wr_addr == rd_idx) ? wr_data : pix_buf[rd_idx];
          pix_last  <= (idx == LAST);
          pix_valid <= 1'b1;
          state     <= StPresent;
        end
        StPresent: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (pix_last) begin
              state <= StDone;
            end else begin
              idx   <= idx + 1'b1;
              state <= StFetch;
            end
          end
        end
        StDone: begin
          pix_last <= 1'b0;
          if (rot_en) base <= (base == LAST) ? '0 : base + 1'b1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// Directed and randomized bench for ws2812_pixel_feeder against an array model of the buffer
// and a frame-level model of word order, rotation, timing and refresh.
module tb_ws2812_pixel_feeder;

  localparam int N  = 3;
  localparam int AW = 2;
  localparam int RC = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          auto_en = 1'b0;
  logic          rot_en = 1'b0;
  logic          pix_ready = 1'b0;
  logic          pix_valid;
  logic [23:0]   pix_data;
  logic          pix_last;
  logic          frame_busy;
  logic          frame_done;

  int          total = 0;
  int          bad = 0;
  logic [23:0] mem [N];
  int          base_m = 0;

  always #5 clk = ~clk;

  ws2812_pixel_feeder #(
    .NUM_LEDS      (N),
    .ADDR_W        (AW),
    .REFRESH_CYCLES(RC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .auto_en   (auto_en),
    .rot_en    (rot_en),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .pix_ready (pix_ready),
    .frame_busy(frame_busy),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int a, input logic [23:0] d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
    if (a < N) mem[a] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Consume one whole frame; first_gap < 0 skips the first-word latency check.
  task automatic run_frame(input int stall_word, input int stall_len, input bit rnd,
                           input int first_gap);
    int          waited;
    int          st;
    int          wa;
    logic [23:0] exp_w;
    for (int i = 0; i < N; i++) begin
      waited = 0;
      while (pix_valid !== 1'b1 && waited < 400) begin
        step();
        waited++;
      end
      check("word_timeout", 32'(waited < 400), 1);
      if (i > 0) check("word_gap", waited, 1);
      else if (first_gap >= 0) check("first_gap", waited, first_gap);
      exp_w = mem[(base_m + i) % N];
      check("word_data", pix_data, exp_w);
      check("word_last", pix_last, 32'(i == N - 1));
      st = (i == stall_word) ? stall_len : (rnd ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s < st; s++) begin
        pix_ready = 1'b0;
        wa = -1;
        if (rnd && $urandom_range(0, 1) == 1) begin
          wa = int'($urandom_range(0, 3));
          wr_en = 1'b1;
          wr_addr = AW'(wa);
          wr_data = 24'($urandom);
        end
        step();
        if (wa >= 0 && wa < N) mem[wa] = wr_data;
        wr_en = 1'b0;
        check("stall_valid", pix_valid, 1);
        check("stall_data", pix_data, exp_w);
      end
      pix_ready = 1'b1;
      step();
      pix_ready = 1'b0;
      check("xfer_valid_drop", pix_valid, 0);
    end
    check("done_pulse", frame_done, 1);
    check("done_busy", frame_busy, 1);
    if (rot_en) base_m = (base_m + 1) % N;
    step();
    check("done_clear", frame_done, 0);
    check("idle_busy", frame_busy, 0);
  endtask

  initial begin
    int nr;
    int rises [8];
    bit prev;
    bit seen;
    int nw;
    for (int i = 0; i < N; i++) mem[i] = '0;

    // Reset state
    step();
    check("rst_valid", pix_valid, 0);
    check("rst_last", pix_last, 0);
    check("rst_busy", frame_busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_data", pix_data, 0);
    rst_n = 1'b1;
    step();

    // Basic frame, no rotation
    write_px(0, 24'h0000FF);
    write_px(1, 24'h00FF00);
    write_px(2, 24'hFF0000);
    pulse_start();
    check("start_busy", frame_busy, 1);
    check("start_valid", pix_valid, 0);
    run_frame(-1, 0, 1'b0, 1);

    // Rotation over four back-to-back frames
    rot_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      pulse_start();
      run_frame(-1, 0, 1'b0, 1);
    end
    rot_en = 1'b0;

    // Long backpressure on the second word
    pulse_start();
    run_frame(1, 50, 1'b0, 1);

    // Write to the address being fetched during the fetch cycle
    pulse_start();
    wr_en = 1'b1;
    wr_addr = AW'(base_m);
    wr_data = 24'hA5C30F;
    step();
    wr_en = 1'b0;
    mem[base_m] = 24'hA5C30F;
    run_frame(-1, 0, 1'b0, 0);

    // Two requests during a busy frame collapse into one follow-up frame
    pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_frame(-1, 0, 1'b0, -1);
    run_frame(-1, 0, 1'b0, 2);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (frame_busy) seen = 1'b1;
    end
    check("no_third_frame", seen, 0);

    // Random writes, rotation and stalls
    for (int f = 0; f < 8; f++) begin
      nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++) write_px(int'($urandom_range(0, 3)), 24'($urandom));
      rot_en = 1'($urandom_range(0, 1));
      pulse_start();
      run_frame(-1, 0, 1'b1, 1);
    end
    rot_en = 1'b0;

    // Auto refresh: frames every RC cycles, none while disabled, timer restarts from 0
    pix_ready = 1'b1;
    auto_en = 1'b1;
    nr = 0;
    prev = 1'b0;
    for (int k = 1; k <= 720; k++) begin
      step();
      if (frame_busy && !prev) begin
        if (nr < 8) rises[nr] = k;
        nr++;
      end
      prev = frame_busy;
      if (k == 350) auto_en = 1'b0;
      if (k == 600) auto_en = 1'b1;
    end
    auto_en = 1'b0;
    check("auto_count", nr, 4);
    if (nr >= 4) begin
      check("auto_rise0", rises[0], 100);
      check("auto_rise1", rises[1], 200);
      check("auto_rise2", rises[2], 300);
      check("auto_rise3", rises[3], 700);
    end
    repeat (20) step();
    pix_ready = 1'b0;

    // Reset in the middle of a presented word
    write_px(0, 24'h123456);
    write_px(1, 24'h654321);
    write_px(2, 24'hABCDEF);
    pulse_start();
    step();
    check("pre_rst_valid", pix_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", pix_valid, 0);
    check("mid_rst_busy", frame_busy, 0);
    check("mid_rst_data", pix_data, 0);
    check("mid_rst_last", pix_last, 0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = '0;
    base_m = 0;
    step();
    pulse_start();
    run_frame(-1, 0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
